// File: rtl/celda_serial_cmp.sv
// Bit-serial magnitude comparator: scans captured operands MSB->LSB, one bit per clock.
// Optional CELDA_SERIAL_EARLY_EXIT_EN ends the scan on the first differing bit.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// SCAN  | walking idx from WIDTH-1 down to 0, latching the first difference
// DONE  | one-cycle done pulse, result/diff_idx valid
module celda_serial_cmp #(
  parameter int WIDTH      = 8,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic [1:0]               sel,
  output logic                     busy,
  output logic                     done,
  output logic                     result,
  output logic [$clog2(WIDTH)-1:0] diff_idx
);

  localparam int IW = $clog2(WIDTH);

`ifdef CELDA_SERIAL_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    D_EQ = 2'd0,
    D_GT = 2'd1,
    D_LT = 2'd2
  } dec_t;

  state_t          state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]      sel_q;
  dec_t            dec_q;
  dec_t            dec_d;
  logic [IW-1:0]   idx_q;
  logic [IW-1:0]   fidx_q;
  logic            busy_q;
  logic            done_q;
  logic            result_q;
  logic [IW-1:0]   diff_idx_q;

  logic            bit_a;
  logic            bit_b;
  logic            inv;
  logic            hit;
  logic            last;

  function automatic logic mode_result(input logic [1:0] m, input dec_t d);
    case (m)
      2'b00:   return d != D_EQ;
      2'b01:   return d == D_GT;
      2'b10:   return d == D_LT;
      default: return d == D_EQ;
    endcase
  endfunction

  // In signed mode a set sign bit marks the smaller operand, so the
  // decision taken on the MSB is swapped.
  always_comb begin
    bit_a = a_q[idx_q];
    bit_b = b_q[idx_q];
    inv   = SIGNED_CMP && (idx_q == IW'(WIDTH - 1));
    hit   = (dec_q == D_EQ) && (bit_a != bit_b);
    dec_d = dec_q;
    if (hit) begin
      dec_d = (bit_a ^ inv) ? D_GT : D_LT;
    end
    last  = (idx_q == '0) || (EARLY_EXIT && hit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sel_q      <= '0;
      dec_q      <= D_EQ;
      idx_q      <= '0;
      fidx_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= 1'b0;
      diff_idx_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            sel_q   <= sel;
            dec_q   <= D_EQ;
            idx_q   <= IW'(WIDTH - 1);
            fidx_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          dec_q <= dec_d;
          if (hit) begin
            fidx_q <= idx_q;
          end
          if (last) begin
            // fidx_q stays 0 when no bit ever differed.
            result_q   <= mode_result(sel_q, dec_d);
            diff_idx_q <= hit ? idx_q : fidx_q;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign diff_idx = diff_idx_q;

endmodule

// File: tb/tb_celda_serial_cmp.sv
// Scoreboard bench for celda_serial_cmp: an unsigned and a signed instance, WIDTH=8.
// Expected latency follows CELDA_SERIAL_EARLY_EXIT_EN when it is defined.
module tb_celda_serial_cmp;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [1:0]          start;
  logic [1:0][W-1:0]   a;
  logic [1:0][W-1:0]   b;
  logic [1:0][1:0]     sel;
  logic                busy0, done0, result0;
  logic                busy1, done1, result1;
  logic [2:0]          didx0, didx1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       res;
    logic [2:0] idx;
    int         t0;
    int         lat;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  logic       last_res[2];
  logic [2:0] last_idx[2];

  celda_serial_cmp #(.WIDTH(W), .SIGNED_CMP(1'b0)) u_dut (
    .clk(clk), .rst(rst), .start(start[0]), .a(a[0]), .b(b[0]), .sel(sel[0]),
    .busy(busy0), .done(done0), .result(result0), .diff_idx(didx0)
  );

  celda_serial_cmp #(.WIDTH(W), .SIGNED_CMP(1'b1)) u_sdut (
    .clk(clk), .rst(rst), .start(start[1]), .a(a[1]), .b(b[1]), .sel(sel[1]),
    .busy(busy1), .done(done1), .result(result1), .diff_idx(didx1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic [2:0] ix);
`ifdef CELDA_SERIAL_EARLY_EXIT_EN
    return (x != y) ? (W - int'(ix)) : W;
`else
    return W;
`endif
  endfunction

  function automatic logic bsy(input int d);
    return (d == 0) ? busy0 : busy1;
  endfunction

  task automatic mon(input int d, input logic r, input logic [2:0] ix);
    exp_t e;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      total++;
      bad++;
      $display("FAIL unexpected_done dut%0d: got done=1 expected none (cycle %0d)", d, cyc);
    end else begin
      if (d == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      chk($sformatf("result dut%0d", d), r, e.res);
      chk($sformatf("diff_idx dut%0d", d), ix, e.idx);
      chk($sformatf("latency dut%0d", d), cyc - e.t0, e.lat);
    end
  endtask

  always @(negedge clk) begin
    if (done0 === 1'b1) mon(0, result0, didx0);
    if (done1 === 1'b1) mon(1, result1, didx1);
  end

  task automatic push(input int d, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic er, input logic [2:0] ei);
    exp_t e;
    e.res = er;
    e.idx = ei;
    e.t0  = cyc + 1;
    e.lat = exp_lat(x, y, ei);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Issue one start; afterwards scramble the inputs to prove they were captured.
  task automatic issue(input int d, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [1:0] s, input logic er, input logic [2:0] ei);
    @(posedge clk); #1;
    start[d] = 1'b1;
    a[d]     = x;
    b[d]     = y;
    sel[d]   = s;
    push(d, x, y, er, ei);
    @(posedge clk); #1;
    start[d] = 1'b0;
    a[d]     = ~x;
    b[d]     = x;
    sel[d]   = ~s;
    chk($sformatf("busy_after_start dut%0d", d), bsy(d), 1'b1);
    chk($sformatf("result_hold dut%0d", d), (d == 0) ? result0 : result1, last_res[d]);
    chk($sformatf("diff_idx_hold dut%0d", d), (d == 0) ? didx0 : didx1, last_idx[d]);
    last_res[d] = er;
    last_idx[d] = ei;
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    while (bsy(d) !== 1'b0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) chk($sformatf("idle_timeout dut%0d", d), 1'b1, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish by 100000ns");
    $fatal(1, "timeout");
  end

  initial begin
    rst      = 1'b1;
    start    = 2'b00;
    a        = '0;
    b        = '0;
    sel      = '0;
    last_res = '{1'b0, 1'b0};
    last_idx = '{3'd0, 3'd0};

    // Reset held with start asserted, then one operation on release.
    start[0] = 1'b1;
    a[0]     = 8'h05;
    b[0]     = 8'h03;
    sel[0]   = 2'b01;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy0, 1'b0);
    chk("reset done", done0, 1'b0);
    chk("reset result", result0, 1'b0);
    chk("reset diff_idx", didx0, 3'd0);
    chk("reset busy signed", busy1, 1'b0);
    rst = 1'b0;
    push(0, 8'h05, 8'h03, 1'b1, 3'd2);
    @(posedge clk); #1;
    start[0] = 1'b0;
    chk("busy_after_release", busy0, 1'b1);
    last_res[0] = 1'b1;
    last_idx[0] = 3'd2;
    wait_idle(0);

    issue(0, 8'hA5, 8'hA5, 2'b11, 1'b1, 3'd0); wait_idle(0);
    issue(0, 8'hA5, 8'hA5, 2'b00, 1'b0, 3'd0); wait_idle(0);
    issue(0, 8'h80, 8'h7F, 2'b01, 1'b1, 3'd7); wait_idle(0);
    issue(0, 8'h80, 8'h01, 2'b10, 1'b0, 3'd7); wait_idle(0);

    issue(1, 8'h80, 8'h01, 2'b10, 1'b1, 3'd7); wait_idle(1);
    issue(1, 8'h80, 8'h01, 2'b01, 1'b0, 3'd7); wait_idle(1);
    issue(1, 8'h05, 8'h03, 2'b01, 1'b1, 3'd2); wait_idle(1);

    // Start pulsed mid-scan must be ignored.
    issue(0, 8'h12, 8'h13, 2'b00, 1'b1, 3'd0);
    @(posedge clk); #1;
    start[0] = 1'b1;
    a[0]     = 8'hFF;
    b[0]     = 8'h00;
    sel[0]   = 2'b11;
    @(posedge clk); #1;
    start[0] = 1'b0;
    wait_idle(0);
    repeat (12) @(posedge clk);
    #1;

    // Reset mid-scan: no done, outputs cleared, next start accepted.
    @(posedge clk); #1;
    start[0] = 1'b1;
    a[0]     = 8'h3C;
    b[0]     = 8'h3C;
    sel[0]   = 2'b11;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midscan_reset busy", busy0, 1'b0);
    chk("midscan_reset done", done0, 1'b0);
    chk("midscan_reset result", result0, 1'b0);
    chk("midscan_reset diff_idx", didx0, 3'd0);
    last_res = '{1'b0, 1'b0};
    last_idx = '{3'd0, 3'd0};
    repeat (12) @(posedge clk);
    #1;
    issue(0, 8'h01, 8'h02, 2'b10, 1'b1, 3'd1); wait_idle(0);

    repeat (3) @(posedge clk);
    #1;
    chk("pending_expect dut0", q0.size(), 0);
    chk("pending_expect dut1", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
